// File: rtl/text_anim_pkg.sv
// Shared types and default geometry for the text overlay animation path.
// The overlay generator imports TARGET_Y and SCREEN_H from here as well.
package text_anim_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FALL = 3'd1,
    HOLD = 3'd2,
    EXIT = 3'd3,
    GAP  = 3'd4
  } phase_e;

  localparam logic [9:0] START_Y   = 10'd0;
  localparam logic [9:0] TARGET_Y  = 10'd336;
  localparam logic [9:0] FALL_STEP = 10'd4;
  localparam logic [9:0] EXIT_STEP = 10'd8;
  localparam logic [9:0] SCREEN_H  = 10'd480;

  localparam int MAX_MSGS = 4;
  localparam int CNT_W    = 16;

  // Widened add so position compares cannot be fooled by 10-bit wrap.
  function automatic logic [10:0] add11(input logic [9:0] a, input logic [9:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/text_anim_ctrl_if.sv
// Control/status bundle between the frame scheduler and its consumer.
// next_frame is a one-cycle strobe qualified by enable; there is no back-pressure.
interface text_anim_ctrl_if;

  logic       next_frame;
  logic       enable;
  logic       skip;
  logic [9:0] base_y;
  logic [1:0] msg_sel;
  logic       text_visible;
  logic [2:0] phase;
  logic       done;

  modport master (
    output next_frame, enable, skip,
    input  base_y, msg_sel, text_visible, phase, done
  );

  modport slave (
    input  next_frame, enable, skip,
    output base_y, msg_sel, text_visible, phase, done
  );

endinterface

// File: rtl/text_anim_ctrl_frame_timer.sv
// Frame-qualified counter shared by the HOLD and GAP phases.
// clr and inc only act on tick; tc flags count == limit-1.
module frame_timer
  import text_anim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + 1'b1;
      end
    end
  end

  assign tc = (count == limit - 1'b1);

endmodule

// File: rtl/text_anim_ctrl.sv
// Frame-rate scheduler: fall-in / hold / exit / gap cycle for the overlay text.
// Define TEXT_ANIM_LOOP_EN to loop forever; otherwise the last message parks in HOLD with done=1.
module text_anim_ctrl #(
  parameter int         NUM_MSGS    = text_anim_pkg::MAX_MSGS,
  parameter logic [9:0] START_Y     = text_anim_pkg::START_Y,
  parameter logic [9:0] TARGET_Y    = text_anim_pkg::TARGET_Y,
  parameter logic [9:0] FALL_STEP   = text_anim_pkg::FALL_STEP,
  parameter logic [9:0] EXIT_STEP   = text_anim_pkg::EXIT_STEP,
  parameter logic [9:0] SCREEN_H    = text_anim_pkg::SCREEN_H,
  parameter int         HOLD_FRAMES = 120,
  parameter int         GAP_FRAMES  = 30
) (
  input logic             clk,
  input logic             rst,
  text_anim_ctrl_if.slave bus
);

  import text_anim_pkg::phase_e;
  import text_anim_pkg::IDLE;
  import text_anim_pkg::FALL;
  import text_anim_pkg::HOLD;
  import text_anim_pkg::EXIT;
  import text_anim_pkg::GAP;
  import text_anim_pkg::CNT_W;
  import text_anim_pkg::add11;

  phase_e     state;
  logic [9:0] base_y_q;
  logic [1:0] msg_q;
  logic       vis_q;
  logic       done_q;
  logic       skip_q;

  logic        step;
  logic        skip_ok;
  logic        skip_eff;
  logic        parked;
  logic        last_msg;
  logic [10:0] fall_sum;
  logic [10:0] exit_sum;
  logic        fall_hit;
  logic        exit_hit;
  logic        tm_clr;
  logic        tm_inc;
  logic        tm_tc;
  logic [CNT_W-1:0] tm_limit;

  assign step     = bus.next_frame & bus.enable;
  assign skip_ok  = (state == FALL) || (state == HOLD);
  // A skip arriving with the frame strobe counts on that same edge.
  assign skip_eff = skip_q | (bus.skip & skip_ok);
  assign last_msg = (msg_q == 2'(NUM_MSGS - 1));
  assign fall_sum = add11(base_y_q, FALL_STEP);
  assign exit_sum = add11(base_y_q, EXIT_STEP);
  assign fall_hit = (fall_sum >= {1'b0, TARGET_Y});
  assign exit_hit = (exit_sum >= {1'b0, SCREEN_H});

`ifdef TEXT_ANIM_LOOP_EN
  assign parked = 1'b0;
`else
  assign parked = done_q;
`endif

  assign tm_clr   = ((state == FALL) && !skip_eff && fall_hit) ||
                    ((state == EXIT) && exit_hit);
  assign tm_inc   = (state == GAP) || ((state == HOLD) && !parked);
  assign tm_limit = (state == GAP) ? CNT_W'(GAP_FRAMES) : CNT_W'(HOLD_FRAMES);

  frame_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (step),
    .clr   (tm_clr),
    .inc   (tm_inc),
    .limit (tm_limit),
    .tc    (tm_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_y_q <= START_Y;
      msg_q    <= 2'd0;
      vis_q    <= 1'b0;
      done_q   <= 1'b0;
      skip_q   <= 1'b0;
    end else if (bus.enable) begin
      if (step) begin
        skip_q <= 1'b0;
        case (state)
          IDLE: begin
            state    <= FALL;
            base_y_q <= START_Y;
            vis_q    <= 1'b1;
          end
          FALL: begin
            if (skip_eff) begin
              state    <= EXIT;
              base_y_q <= exit_hit ? SCREEN_H : exit_sum[9:0];
            end else if (fall_hit) begin
              state    <= HOLD;
              base_y_q <= TARGET_Y;
`ifndef TEXT_ANIM_LOOP_EN
              if (last_msg) done_q <= 1'b1;
`endif
            end else begin
              base_y_q <= fall_sum[9:0];
            end
          end
          HOLD: begin
            if (!parked && (tm_tc || skip_eff)) state <= EXIT;
          end
          EXIT: begin
            if (exit_hit) begin
              state    <= GAP;
              base_y_q <= SCREEN_H;
              vis_q    <= 1'b0;
            end else begin
              base_y_q <= exit_sum[9:0];
            end
          end
          GAP: begin
            if (tm_tc) begin
              state    <= FALL;
              msg_q    <= last_msg ? 2'd0 : msg_q + 2'd1;
              base_y_q <= START_Y;
              vis_q    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (bus.skip) begin
        // Skip outside FALL/HOLD is dropped and clears any pending request.
        skip_q <= skip_ok;
      end
    end
  end

  assign bus.base_y       = base_y_q;
  assign bus.msg_sel      = msg_q;
  assign bus.text_visible = vis_q;
  assign bus.phase        = state;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_text_anim_ctrl.sv
// Directed bench for text_anim_ctrl: a default-parameter instance (a) and a short-cycle instance (b).
// Expectations for the last-message behaviour follow TEXT_ANIM_LOOP_EN.
module tb_text_anim_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic next_frame = 1'b0;
  logic enable = 1'b1;
  logic skip_a = 1'b0;
  logic skip_b = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  text_anim_ctrl_if if_a ();
  text_anim_ctrl_if if_b ();

  assign if_a.next_frame = next_frame;
  assign if_a.enable     = enable;
  assign if_a.skip       = skip_a;
  assign if_b.next_frame = next_frame;
  assign if_b.enable     = enable;
  assign if_b.skip       = skip_b;

  text_anim_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  text_anim_ctrl #(
    .NUM_MSGS    (2),
    .TARGET_Y    (10'd10),
    .HOLD_FRAMES (3),
    .GAP_FRAMES  (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame strobe; returns at the falling edge after the update edge.
  task automatic do_frame(input logic sa, input logic sb);
    @(negedge clk);
    next_frame = 1'b1;
    skip_a     = sa;
    skip_b     = sb;
    @(negedge clk);
    next_frame = 1'b0;
    skip_a     = 1'b0;
    skip_b     = 1'b0;
  endtask

  initial begin
    logic sb;
    logic exp_done;
`ifdef TEXT_ANIM_LOOP_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_base", 32'(if_a.base_y), 0);
    chk("rst_a_msg", 32'(if_a.msg_sel), 0);
    chk("rst_a_vis", 32'(if_a.text_visible), 0);
    chk("rst_a_phase", 32'(if_a.phase), 0);
    chk("rst_a_done", 32'(if_a.done), 0);
    chk("rst_b_phase", 32'(if_b.phase), 0);

    for (int f = 1; f <= 136; f++) begin
      sb = 1'b0;
`ifndef TEXT_ANIM_LOOP_EN
      if (f == 72) sb = 1'b1;
`endif
      do_frame(1'b0, sb);
      if (f == 1) begin
        chk("f1_a_phase", 32'(if_a.phase), 1);
        chk("f1_a_base", 32'(if_a.base_y), 0);
        chk("f1_a_vis", 32'(if_a.text_visible), 1);
        chk("f1_b_phase", 32'(if_b.phase), 1);
      end
      if (f == 3) chk("f3_b_base", 32'(if_b.base_y), 8);
      if (f == 4) begin
        chk("f4_a_base", 32'(if_a.base_y), 12);
        chk("f4_b_base", 32'(if_b.base_y), 10);
        chk("f4_b_phase", 32'(if_b.phase), 2);
      end
      if (f == 6) chk("f6_b_phase", 32'(if_b.phase), 2);
      if (f == 7) begin
        chk("f7_b_phase", 32'(if_b.phase), 3);
        chk("f7_b_base", 32'(if_b.base_y), 10);
      end
      if (f == 8) chk("f8_b_base", 32'(if_b.base_y), 18);
      if (f == 10) begin
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) do_frame(1'b0, 1'b0);
        chk("hold_a_base", 32'(if_a.base_y), 36);
        chk("hold_a_phase", 32'(if_a.phase), 1);
        chk("hold_b_base", 32'(if_b.base_y), 34);
        chk("hold_b_phase", 32'(if_b.phase), 3);
        enable = 1'b1;
      end
      if (f == 11) chk("f11_a_base", 32'(if_a.base_y), 40);
      if (f == 65) begin
        chk("f65_b_base", 32'(if_b.base_y), 474);
        chk("f65_b_vis", 32'(if_b.text_visible), 1);
      end
      if (f == 66) begin
        chk("f66_b_base", 32'(if_b.base_y), 480);
        chk("f66_b_vis", 32'(if_b.text_visible), 0);
        chk("f66_b_phase", 32'(if_b.phase), 4);
        @(negedge clk);
        skip_b = 1'b1;
        @(negedge clk);
        skip_b = 1'b0;
      end
      if (f == 67) begin
        chk("f67_b_phase", 32'(if_b.phase), 4);
        chk("f67_b_msg", 32'(if_b.msg_sel), 0);
      end
      if (f == 68) begin
        chk("f68_b_msg", 32'(if_b.msg_sel), 1);
        chk("f68_b_base", 32'(if_b.base_y), 0);
        chk("f68_b_phase", 32'(if_b.phase), 1);
        chk("f68_b_vis", 32'(if_b.text_visible), 1);
      end
      if (f == 71) begin
        chk("f71_b_base", 32'(if_b.base_y), 10);
        chk("f71_b_phase", 32'(if_b.phase), 2);
        chk("f71_b_done", 32'(if_b.done), 32'(exp_done));
      end
      if (f == 84) begin
        chk("f84_a_base", 32'(if_a.base_y), 332);
        chk("f84_a_phase", 32'(if_a.phase), 1);
      end
      if (f == 85) begin
        chk("f85_a_base", 32'(if_a.base_y), 336);
        chk("f85_a_phase", 32'(if_a.phase), 2);
        chk("f85_a_vis", 32'(if_a.text_visible), 1);
      end
`ifdef TEXT_ANIM_LOOP_EN
      if (f == 73) chk("f73_b_phase", 32'(if_b.phase), 2);
      if (f == 74) begin
        chk("f74_b_phase", 32'(if_b.phase), 3);
        chk("f74_b_base", 32'(if_b.base_y), 10);
      end
      if (f == 133) chk("f133_b_phase", 32'(if_b.phase), 4);
      if (f == 134) chk("f134_b_msg", 32'(if_b.msg_sel), 1);
      if (f == 135) begin
        chk("f135_b_msg", 32'(if_b.msg_sel), 0);
        chk("f135_b_phase", 32'(if_b.phase), 1);
        chk("f135_b_done", 32'(if_b.done), 0);
      end
`else
      if (f == 72 || f == 73 || f == 136) begin
        chk("park_b_phase", 32'(if_b.phase), 2);
        chk("park_b_done", 32'(if_b.done), 1);
        chk("park_b_base", 32'(if_b.base_y), 10);
        chk("park_b_msg", 32'(if_b.msg_sel), 1);
      end
`endif
      if (f == 136) chk("f136_a_phase", 32'(if_a.phase), 2);
    end

    // Asynchronous reset mid-HOLD, sampled before the next rising edge.
    #1 rst = 1'b1;
    #1;
    chk("arst_a_base", 32'(if_a.base_y), 0);
    chk("arst_a_msg", 32'(if_a.msg_sel), 0);
    chk("arst_a_phase", 32'(if_a.phase), 0);
    chk("arst_a_vis", 32'(if_a.text_visible), 0);
    chk("arst_b_done", 32'(if_b.done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int f = 1; f <= 28; f++) begin
      do_frame(f == 27, 1'b0);
      if (f == 26) begin
        chk("sk26_a_base", 32'(if_a.base_y), 100);
        chk("sk26_a_phase", 32'(if_a.phase), 1);
      end
      if (f == 27) begin
        chk("sk27_a_base", 32'(if_a.base_y), 108);
        chk("sk27_a_phase", 32'(if_a.phase), 3);
      end
      if (f == 28) begin
        chk("sk28_a_base", 32'(if_a.base_y), 116);
        chk("sk28_a_phase", 32'(if_a.phase), 3);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/text_anim_ctrl.md
Name: text_anim_ctrl

Overview:
Frame-rate scheduler for the text overlay generator. Selects one of NUM_MSGS messages and moves it through a fall-in, hold, exit and gap cycle. Drives the overlay's vertical base position and message select. Advances only on next_frame pulses, so the overlay datapath stays purely combinational per pixel.

Parameters:
NUM_MSGS, 4, number of messages cycled (2..4; msg_sel width fixed at 2)
START_Y, 10'd0, base_y loaded at the start of each fall
TARGET_Y, 10'd336, resting base_y for the hold phase
FALL_STEP, 10'd4, base_y increment per frame during fall
EXIT_STEP, 10'd8, base_y increment per frame during exit
SCREEN_H, 10'd480, base_y at or beyond which text is off-screen
HOLD_FRAMES, 120, frames spent resting at TARGET_Y (>=1)
GAP_FRAMES, 30, blank frames between messages (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
next_frame  in  1  one-cycle pulse per frame
enable  in  1  run/pause; low freezes all state and outputs
skip  in  1  one-cycle request to end the current message early
base_y  out  10  top of line 0, to the overlay generator
msg_sel  out  2  current message index
text_visible  out  1  overlay draw enable
phase  out  3  state code: IDLE=0, FALL=1, HOLD=2, EXIT=3, GAP=4
done  out  1  sequence finished (non-loop build only)

Behaviour:
- Reset values: state IDLE, base_y=START_Y, msg_sel=0, text_visible=0, done=0, frame counter=0, skip latch=0.
- All outputs are registered. A state update occurs only on a clk edge where next_frame=1 and enable=1, so outputs change one cycle after the pulse.
- skip latch: set by skip=1 in FALL or HOLD. Consumed at the next qualifying frame edge. If skip and next_frame arrive in the same cycle, skip takes effect on that edge. skip in IDLE, EXIT or GAP is discarded and the latch is cleared. The latch also holds while enable=0.
- IDLE: next frame edge → FALL with base_y=START_Y and text_visible=1.
- FALL:
  - If skip is latched → EXIT, with base_y += EXIT_STEP.
  - Else compute base_y + FALL_STEP in 11 bits. If the result is >= TARGET_Y, base_y=TARGET_Y, the counter clears and the state → HOLD. Otherwise base_y takes the sum.
- HOLD:
  - The counter increments each frame.
  - At count == HOLD_FRAMES-1, or when skip is latched → EXIT. base_y does not move on that edge.
- EXIT:
  - Compute base_y + EXIT_STEP in 11 bits.
  - If the result is >= SCREEN_H: base_y=SCREEN_H (clamped), text_visible=0, counter cleared, state → GAP.
  - Otherwise base_y takes the sum.
- GAP:
  - The counter increments each frame.
  - At count == GAP_FRAMES-1: msg_sel advances, wrapping from NUM_MSGS-1 to 0. base_y=START_Y, text_visible=1, state → FALL.
- base_y never exceeds SCREEN_H and never wraps.
- enable=0 mid-operation: everything holds, with no partial updates.
- Reset asserted mid-operation returns all registers to their reset values immediately, independent of clk.

Optional Feature:
TEXT_ANIM_LOOP_EN
- Defined: after the last message's GAP, msg_sel wraps to 0 and the sequence loops forever. done stays 0.
- Undefined: the last message (msg_sel=NUM_MSGS-1), on reaching HOLD, stays in HOLD indefinitely with done=1. HOLD_FRAMES and skip are ignored there. Earlier messages behave as above. done clears only on reset.

Decomposition:
- Package text_anim_pkg holds:
  - the phase enum (IDLE/FALL/HOLD/EXIT/GAP, 3-bit);
  - default constants START_Y, TARGET_Y, FALL_STEP, EXIT_STEP, SCREEN_H;
  - the message-count limit.
  The overlay generator imports the same TARGET_Y and SCREEN_H.
- One sub-module, frame_timer: a frame-qualified counter with sync clear, an increment enable and a terminal-count compare (count == limit-1). It is shared by HOLD and GAP, which are mutually exclusive.

Test Plan:
1. Default params, enable=1, pulse next_frame → base_y reaches 336 after 85 frames (1 start + 84 steps). phase=2 on the 85th edge. text_visible=1 throughout.
2. TARGET_Y=10, FALL_STEP=4 → base_y sequence 0, 4, 8, 10, then HOLD. No overshoot.
3. HOLD_FRAMES=3, GAP_FRAMES=2 → 3 frames in HOLD, then exit: base_y 336, 344, …, 472, 480 clamped. text_visible drops when base_y hits 480. After 2 GAP frames, msg_sel=1 and base_y=0.
4. Skip in the same cycle as next_frame while in FALL at base_y=100 → next base_y=108 with phase=3. Skip in GAP → ignored.
5. enable=0 for 10 frames mid-FALL → base_y unchanged. Assert rst mid-HOLD → base_y=0, msg_sel=0, phase=0 with no clk edge needed.
6. NUM_MSGS=2:
   - with LOOP_EN, msg_sel sequence 0, 1, 0;
   - without it, msg_sel=1 parks in HOLD, done=1, and skip is ignored.
